// File: rtl/ocdve_apb_pkg.sv
`default_nettype none
// ============================================================================
// Module : ocdve_apb_pkg
// Brief  : Shared types and helpers for the APB requester and its wait timer.
// Rev    : 1.0
// ============================================================================
package ocdve_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_e;

    // Counter width for a wait limit; a limit below 1 is treated as 1.
    function automatic int timer_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ocdve_apb_wait_timer.sv
`default_nettype none
// ============================================================================
// Module : ocdve_apb_wait_timer
// Brief  : Clear/enable counter flagging the LIMIT-th enabled cycle.
// Rev    : 1.0
// ============================================================================
module ocdve_apb_wait_timer
    import ocdve_apb_pkg::*;
#(
    parameter int LIMIT = 16,
    parameter int WIDTH = timer_width(LIMIT)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [WIDTH-1:0] c_LAST = WIDTH'((LIMIT < 1) ? 0 : LIMIT - 1);

    logic [WIDTH-1:0] r_count_q;
    logic [WIDTH-1:0] w_count_d;

    // The count holds the number of earlier enabled cycles, so the
    // current enabled cycle is the LIMIT-th one when it equals LIMIT-1.
    always_comb begin
        w_count_d = r_count_q;
        if (i_clear) begin
            w_count_d = '0;
        end else if (i_enable && (r_count_q != c_LAST)) begin
            w_count_d = r_count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

    assign o_expired = i_enable && (r_count_q == c_LAST);

endmodule
`default_nettype wire

// File: rtl/ocdve_apb_req_master.sv
`default_nettype none
// ============================================================================
// Module : ocdve_apb_req_master
// Brief  : valid/ready command stream to APB3 SETUP/ACCESS transfers, one
//          response per command. Optional wait timeout: OCDVE_APB_TIMEOUT_EN.
// Rev    : 1.0
// ============================================================================
module ocdve_apb_req_master
    import ocdve_apb_pkg::*;
#(
    parameter int PADDR_WIDTH    = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [PADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]  req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_WIDTH-1:0]  rsp_rdata,
    output logic                   rsp_err,
    output logic                   rsp_timeout,
    output logic [PADDR_WIDTH-1:0] paddr,
    output logic                   psel,
    output logic                   penable,
    output logic                   pwrite,
    output logic [DATA_WIDTH-1:0]  pwdata,
    input  logic                   pready,
    input  logic [DATA_WIDTH-1:0]  prdata,
    input  logic                   pslverr
);

    apb_mst_state_e         r_state_q,     w_state_d;
    logic                   r_psel_q,      w_psel_d;
    logic                   r_penable_q,   w_penable_d;
    logic                   r_pwrite_q,    w_pwrite_d;
    logic [PADDR_WIDTH-1:0] r_paddr_q,     w_paddr_d;
    logic [DATA_WIDTH-1:0]  r_pwdata_q,    w_pwdata_d;
    logic                   r_rsp_valid_q, w_rsp_valid_d;
    logic [DATA_WIDTH-1:0]  r_rsp_rdata_q, w_rsp_rdata_d;
    logic                   r_rsp_err_q,   w_rsp_err_d;

`ifdef OCDVE_APB_TIMEOUT_EN
    logic r_rsp_timeout_q, w_rsp_timeout_d;
    logic w_timer_expired;

    ocdve_apb_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clear   (r_state_q != ACCESS),
        .i_enable  ((r_state_q == ACCESS) && !pready),
        .o_expired (w_timer_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rsp_timeout_q <= 1'b0;
        end else begin
            r_rsp_timeout_q <= w_rsp_timeout_d;
        end
    end

    assign rsp_timeout = r_rsp_timeout_q;
`else
    // Never true for a legal limit; the wait limit has no other role here.
    assign rsp_timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        w_state_d     = r_state_q;
        w_psel_d      = r_psel_q;
        w_penable_d   = r_penable_q;
        w_pwrite_d    = r_pwrite_q;
        w_paddr_d     = r_paddr_q;
        w_pwdata_d    = r_pwdata_q;
        w_rsp_valid_d = r_rsp_valid_q;
        w_rsp_rdata_d = r_rsp_rdata_q;
        w_rsp_err_d   = r_rsp_err_q;
`ifdef OCDVE_APB_TIMEOUT_EN
        w_rsp_timeout_d = r_rsp_timeout_q;
`endif
        case (r_state_q)
            IDLE: begin
                if (req_valid) begin
                    w_state_d   = SETUP;
                    w_psel_d    = 1'b1;
                    w_penable_d = 1'b0;
                    w_pwrite_d  = req_write;
                    w_paddr_d   = req_addr;
                    w_pwdata_d  = req_wdata;
                end
            end
            SETUP: begin
                w_state_d   = ACCESS;
                w_penable_d = 1'b1;
            end
            ACCESS: begin
                // Completion takes priority over an expiring timer.
                if (pready) begin
                    w_state_d     = RESP;
                    w_psel_d      = 1'b0;
                    w_penable_d   = 1'b0;
                    w_rsp_valid_d = 1'b1;
                    w_rsp_rdata_d = r_pwrite_q ? '0 : prdata;
                    w_rsp_err_d   = pslverr;
`ifdef OCDVE_APB_TIMEOUT_EN
                    w_rsp_timeout_d = 1'b0;
                end else if (w_timer_expired) begin
                    w_state_d       = RESP;
                    w_psel_d        = 1'b0;
                    w_penable_d     = 1'b0;
                    w_rsp_valid_d   = 1'b1;
                    w_rsp_rdata_d   = '0;
                    w_rsp_err_d     = 1'b1;
                    w_rsp_timeout_d = 1'b1;
`endif
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_d     = IDLE;
                    w_rsp_valid_d = 1'b0;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state_q     <= IDLE;
            r_psel_q      <= 1'b0;
            r_penable_q   <= 1'b0;
            r_pwrite_q    <= 1'b0;
            r_paddr_q     <= '0;
            r_pwdata_q    <= '0;
            r_rsp_valid_q <= 1'b0;
            r_rsp_rdata_q <= '0;
            r_rsp_err_q   <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_psel_q      <= w_psel_d;
            r_penable_q   <= w_penable_d;
            r_pwrite_q    <= w_pwrite_d;
            r_paddr_q     <= w_paddr_d;
            r_pwdata_q    <= w_pwdata_d;
            r_rsp_valid_q <= w_rsp_valid_d;
            r_rsp_rdata_q <= w_rsp_rdata_d;
            r_rsp_err_q   <= w_rsp_err_d;
        end
    end

    assign req_ready = (r_state_q == IDLE) && reset_n;
    assign psel      = r_psel_q;
    assign penable   = r_penable_q;
    assign pwrite    = r_pwrite_q;
    assign paddr     = r_paddr_q;
    assign pwdata    = r_pwdata_q;
    assign rsp_valid = r_rsp_valid_q;
    assign rsp_rdata = r_rsp_rdata_q;
    assign rsp_err   = r_rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ocdve_apb_req_master.sv
`default_nettype none
// ============================================================================
// Module : tb_ocdve_apb_req_master
// Brief  : Directed and random transfers checked cycle by cycle against a
//          transaction-level model of the APB requester.
// Rev    : 1.0
// ============================================================================
module tb_ocdve_apb_req_master;

    localparam int c_TO = 4;
`ifdef OCDVE_APB_TIMEOUT_EN
    localparam bit c_TO_EN = 1'b1;
`else
    localparam bit c_TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [31:0] paddr, pwdata, prdata;
    logic        psel, penable, pwrite, pready, pslverr;

    int n_chk  = 0;
    int n_fail = 0;

    ocdve_apb_req_master #(
        .PADDR_WIDTH    (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (c_TO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .paddr       (paddr),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .pwdata      (pwdata),
        .pready      (pready),
        .prdata      (prdata),
        .pslverr     (pslverr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One command, modelled as: 1 SETUP cycle, then either waits+1 ACCESS
    // cycles or, when the timer fires first, c_TO ACCESS cycles; then RESP.
    task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input bit slverr, input int waits,
                          input int rsp_hold);
        bit          timed_out;
        int          acc_cycles;
        logic [31:0] exp_rdata;
        bit          exp_err;
        timed_out  = c_TO_EN && (waits >= c_TO);
        acc_cycles = timed_out ? c_TO : waits + 1;
        exp_rdata  = (timed_out || wr) ? 32'd0 : rdata;
        exp_err    = timed_out ? 1'b1 : slverr;

        chk("idle_req_ready", req_ready, 1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        tick();
        // Noise that the DUT must ignore outside IDLE / ACCESS.
        req_valid = 1'($urandom_range(0, 1));
        req_write = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        req_wdata = $urandom;
        pready    = 1'($urandom_range(0, 1));
        pslverr   = 1'($urandom_range(0, 1));
        prdata    = $urandom;
        chk("setup_psel", psel, 1);
        chk("setup_penable", penable, 0);
        chk("setup_req_ready", req_ready, 0);
        chk("setup_rsp_valid", rsp_valid, 0);
        chk("setup_paddr", paddr, addr);
        chk("setup_pwrite", pwrite, wr);
        chk("setup_pwdata", pwdata, wdata);
        tick();
        for (int i = 0; i < acc_cycles; i++) begin
            chk("access_psel", psel, 1);
            chk("access_penable", penable, 1);
            chk("access_paddr", paddr, addr);
            chk("access_pwrite", pwrite, wr);
            chk("access_pwdata", pwdata, wdata);
            chk("access_rsp_valid", rsp_valid, 0);
            chk("access_req_ready", req_ready, 0);
            pready  = (i == waits);
            prdata  = (i == waits) ? rdata : $urandom;
            pslverr = (i == waits) ? slverr : 1'($urandom_range(0, 1));
            tick();
        end
        pready    = 1'b0;
        req_valid = 1'b1;
        for (int d = 0; d <= rsp_hold; d++) begin
            chk("resp_valid", rsp_valid, 1);
            chk("resp_rdata", rsp_rdata, exp_rdata);
            chk("resp_err", rsp_err, exp_err);
            chk("resp_timeout", rsp_timeout, timed_out);
            chk("resp_psel", psel, 0);
            chk("resp_penable", penable, 0);
            chk("resp_req_ready", req_ready, 0);
            rsp_ready = (d == rsp_hold);
            tick();
        end
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        chk("done_rsp_valid", rsp_valid, 0);
        chk("done_psel", psel, 0);
        chk("done_paddr_kept", paddr, addr);
        chk("done_pwrite_kept", pwrite, wr);
        chk("done_pwdata_kept", pwdata, wdata);
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        pready    = 1'b0;
        prdata    = '0;
        pslverr   = 1'b0;
        tick();
        tick();
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_timeout", rsp_timeout, 0);
        chk("rst_req_ready", req_ready, 0);
        reset_n = 1'b1;
        tick();

        // Zero-wait write, 3-wait read, slave error, response backpressure.
        do_txn(1'b1, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 0, 0);
        do_txn(1'b0, 32'h204, 32'h0, 32'hCAFE0001, 1'b0, 3, 0);
        do_txn(1'b0, 32'h308, 32'h0, 32'h12345678, 1'b1, 0, 0);
        do_txn(1'b1, 32'h40C, 32'h0BADF00D, 32'h0, 1'b0, 1, 5);

        // Reset during the second ACCESS cycle.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h500;
        tick();
        req_valid = 1'b0;
        pready    = 1'b0;
        tick();
        tick();
        chk("mid_access_penable", penable, 1);
        reset_n = 1'b0;
        pready  = 1'b1;
        tick();
        chk("midrst_psel", psel, 0);
        chk("midrst_penable", penable, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_paddr", paddr, 0);
        chk("midrst_req_ready", req_ready, 0);
        reset_n = 1'b1;
        pready  = 1'b0;
        tick();
        chk("postrst_req_ready", req_ready, 1);
        chk("postrst_rsp_valid", rsp_valid, 0);
        chk("postrst_psel", psel, 0);

        // Slave never ready: aborts with the timer, otherwise waits 100+ cycles.
        do_txn(1'b0, 32'h600, 32'h0, 32'hA5A5A5A5, 1'b0, 100, 1);
        // Ready exactly on the limit cycle completes normally.
        do_txn(1'b0, 32'h604, 32'h0, 32'h5A5A5A5A, 1'b0, c_TO - 1, 0);

        for (int t = 0; t < 24; t++) begin
            do_txn(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 6)),
                   int'($urandom_range(0, 3)));
            repeat (int'($urandom_range(0, 2))) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
